// File: rtl/pb_bus_pkg.sv
// Shared types and constants for the parallel board bus sequencer.
package pb_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRE_DELAY = 3'd1,
    ST_ADDR      = 3'd2,
    ST_SETUP     = 3'd3,
    ST_STROBE    = 3'd4,
    ST_RELEASE   = 3'd5,
    ST_NEXT      = 3'd6,
    ST_RESPOND   = 3'd7
  } state_e;

  typedef enum logic [1:0] {
    MODE_WRITE = 2'd0,
    MODE_READ  = 2'd1,
    MODE_TEST  = 2'd2,
    MODE_BCAST = 2'd3
  } mode_e;

  // Bus strobes are active low
  localparam logic ENABLE  = 1'b0;
  localparam logic DISABLE = 1'b1;

  localparam logic DIR_DRIVE = 1'b1;
  localparam logic DIR_INPUT = 1'b0;

  localparam int CNT_W      = 16;
  localparam int MAX_BOARDS = 8;

  // Index of the lowest set bit; 0 when the mask is empty
  function automatic logic [2:0] first_board(input logic [7:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 3'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pb_wait_counter.sv
// Down-counter shared by the timed sequencer states: start loads a cycle
// count, done is high on the last cycle of that interval.
module pb_wait_counter
  import pb_bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] load_value,
  output logic             done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_r;

  // Count register: load (value - 1) on start, then decrement to zero and hold
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (start) begin
      cnt_r <= (load_value == '0) ? '0 : load_value - CNT_ONE;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign done = (cnt_r == '0);

endmodule

// File: rtl/pb_bus_sequencer.sv
// Parallel board-bus sequencer: visits each selected board with an
// address/setup/strobe/release cycle. Define PB_BROADCAST_EN for mode 3 broadcast.
module pb_bus_sequencer
  import pb_bus_pkg::*;
#(
  parameter int CLOCK_FREQUENCY  = 27000000,
  parameter int NUM_BOARDS       = 4,
  parameter int DATA_W           = 8,
  parameter int PRE_DELAY_CYCLES = 4,
  parameter int SETUP_CYCLES     = 21,
  parameter int STROBE_CYCLES    = 21
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_mode,
  input  logic [NUM_BOARDS-1:0]        cmd_board_mask,
  input  logic [2:0]                   cmd_addr,
  input  logic [NUM_BOARDS*DATA_W-1:0] cmd_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [NUM_BOARDS*DATA_W-1:0] rsp_data,
  output logic [3:0]                   rsp_count,
  output logic                         rsp_error,
  output logic [NUM_BOARDS-1:0]        BOARD_X,
  output logic [2:0]                   AddessPort,
  output logic                         PB_RD,
  output logic                         PB_WR,
  output logic [DATA_W-1:0]            Data_Out_Port,
  input  logic [DATA_W-1:0]            Data_In_Port,
  output logic                         data_dir
);

  if ((NUM_BOARDS < 1) || (NUM_BOARDS > MAX_BOARDS)) begin : g_bad_boards
    $error("pb_bus_sequencer: NUM_BOARDS must be 1..8");
  end
  if ((SETUP_CYCLES < 1) || (STROBE_CYCLES < 1) || (PRE_DELAY_CYCLES < 1)) begin : g_bad_timing
    $error("pb_bus_sequencer: cycle counts must be at least 1");
  end
  if (CLOCK_FREQUENCY < 1) begin : g_bad_clock
    $error("pb_bus_sequencer: CLOCK_FREQUENCY must be positive");
  end

  state_e                       state_r;
  mode_e                        mode_r;
  logic [2:0]                   addr_r;
  logic [NUM_BOARDS*DATA_W-1:0] wdata_r;
  logic [NUM_BOARDS-1:0]        pend_r;
  logic [2:0]                   idx_r;

  logic                  accept_s;
  logic                  cnt_start_s;
  logic                  cnt_done_s;
  logic [CNT_W-1:0]      cnt_load_s;
  logic [2:0]            nxt_idx_s;
  logic [NUM_BOARDS-1:0] nxt_onehot_s;
  logic [DATA_W-1:0]     nxt_wdata_s;
  logic                  drive_s;
  logic                  is_wr_s;
  logic                  is_rd_s;

  assign accept_s = cmd_valid && cmd_ready;
  assign drive_s  = (mode_r == MODE_WRITE) || (mode_r == MODE_BCAST);
  assign is_wr_s  = drive_s || (mode_r == MODE_TEST);
  assign is_rd_s  = (mode_r == MODE_READ) || (mode_r == MODE_TEST);

  // Next board to visit: lowest still-pending mask bit
  always_comb begin
    nxt_idx_s    = first_board(8'(pend_r));
    nxt_onehot_s = NUM_BOARDS'(1'b1) << nxt_idx_s;
    nxt_wdata_s  = wdata_r[nxt_idx_s*DATA_W +: DATA_W];
  end

  // Counter reload on entry to each timed state
  always_comb begin
    cnt_start_s = 1'b0;
    cnt_load_s  = CNT_W'(PRE_DELAY_CYCLES);
    case (state_r)
      ST_IDLE: begin
        cnt_start_s = accept_s;
        cnt_load_s  = CNT_W'(PRE_DELAY_CYCLES);
      end
      ST_ADDR: begin
        cnt_start_s = 1'b1;
        cnt_load_s  = CNT_W'(SETUP_CYCLES);
      end
      ST_SETUP: begin
        cnt_start_s = cnt_done_s;
        cnt_load_s  = CNT_W'(STROBE_CYCLES);
      end
      default: begin
        cnt_start_s = 1'b0;
        cnt_load_s  = CNT_W'(PRE_DELAY_CYCLES);
      end
    endcase
  end

  pb_wait_counter u_wait (
    .clock      (clock),
    .reset      (reset),
    .start      (cnt_start_s),
    .load_value (cnt_load_s),
    .done       (cnt_done_s)
  );

  // Sequencer FSM with registered bus and response outputs
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r       <= ST_IDLE;
      mode_r        <= MODE_WRITE;
      addr_r        <= 3'd0;
      wdata_r       <= '0;
      pend_r        <= '0;
      idx_r         <= 3'd0;
      cmd_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_error     <= 1'b0;
      rsp_count     <= 4'd0;
      rsp_data      <= '0;
      BOARD_X       <= '0;
      AddessPort    <= 3'd0;
      PB_RD         <= DISABLE;
      PB_WR         <= DISABLE;
      Data_Out_Port <= '0;
      data_dir      <= DIR_INPUT;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r   <= ST_PRE_DELAY;
            cmd_ready <= 1'b0;
            mode_r    <= mode_e'(cmd_mode);
            addr_r    <= cmd_addr;
            wdata_r   <= cmd_wdata;
            pend_r    <= cmd_board_mask;
            rsp_data  <= '0;
            rsp_count <= 4'd0;
            rsp_error <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        // Both states pick the next board; PRE_DELAY waits for its gap first
        ST_PRE_DELAY, ST_NEXT: begin
          if ((state_r == ST_NEXT) || cnt_done_s) begin
            if ((state_r == ST_PRE_DELAY) && (mode_r == MODE_BCAST)) begin
`ifdef PB_BROADCAST_EN
              state_r       <= ST_ADDR;
              pend_r        <= '0;
              BOARD_X       <= '1;
              AddessPort    <= addr_r;
              data_dir      <= DIR_DRIVE;
              Data_Out_Port <= wdata_r[DATA_W-1:0];
              rsp_count     <= 4'd1;
`else
              state_r   <= ST_RESPOND;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
`endif
            end else if (pend_r != '0) begin
              state_r       <= ST_ADDR;
              idx_r         <= nxt_idx_s;
              pend_r        <= pend_r & ~nxt_onehot_s;
              BOARD_X       <= nxt_onehot_s;
              AddessPort    <= addr_r;
              data_dir      <= drive_s ? DIR_DRIVE : DIR_INPUT;
              Data_Out_Port <= drive_s ? nxt_wdata_s : '0;
              rsp_count     <= rsp_count + 4'd1;
            end else begin
              state_r   <= ST_RESPOND;
              rsp_valid <= 1'b1;
            end
          end else begin
            state_r <= state_r;
          end
        end

        ST_ADDR: begin
          state_r <= ST_SETUP;
        end

        ST_SETUP: begin
          if (cnt_done_s) begin
            state_r <= ST_STROBE;
            PB_WR   <= is_wr_s ? ENABLE : DISABLE;
            PB_RD   <= is_rd_s ? ENABLE : DISABLE;
          end else begin
            state_r <= ST_SETUP;
          end
        end

        // Bus data is sampled on the final strobe cycle
        ST_STROBE: begin
          if (cnt_done_s) begin
            state_r  <= ST_RELEASE;
            PB_WR    <= DISABLE;
            PB_RD    <= DISABLE;
            BOARD_X  <= '0;
            data_dir <= DIR_INPUT;
            if (is_rd_s) begin
              rsp_data[idx_r*DATA_W +: DATA_W] <= Data_In_Port;
            end else begin
              rsp_data <= rsp_data;
            end
          end else begin
            state_r <= ST_STROBE;
          end
        end

        ST_RELEASE: begin
          state_r       <= ST_NEXT;
          Data_Out_Port <= '0;
        end

        ST_RESPOND: begin
          if (rsp_ready) begin
            state_r   <= ST_IDLE;
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
          end else begin
            state_r <= ST_RESPOND;
          end
        end

        default: begin
          state_r   <= ST_IDLE;
          cmd_ready <= 1'b1;
          rsp_valid <= 1'b0;
          PB_RD     <= DISABLE;
          PB_WR     <= DISABLE;
          BOARD_X   <= '0;
          data_dir  <= DIR_INPUT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pb_bus_sequencer.sv
// Directed self-checking bench for pb_bus_sequencer (SETUP=3, STROBE=2, PRE_DELAY=4).
module tb_pb_bus_sequencer;

  localparam int NB = 4;
  localparam int DW = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           cmd_valid;
  logic           cmd_ready;
  logic [1:0]     cmd_mode;
  logic [NB-1:0]  cmd_board_mask;
  logic [2:0]     cmd_addr;
  logic [NB*DW-1:0] cmd_wdata;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [NB*DW-1:0] rsp_data;
  logic [3:0]     rsp_count;
  logic           rsp_error;
  logic [NB-1:0]  BOARD_X;
  logic [2:0]     AddessPort;
  logic           PB_RD;
  logic           PB_WR;
  logic [DW-1:0]  Data_Out_Port;
  logic [DW-1:0]  Data_In_Port;
  logic           data_dir;

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [3:0] tr_bx  [64];
  logic       tr_wr  [64];
  logic       tr_rd  [64];
  logic       tr_dir [64];
  logic [7:0] tr_do  [64];
  logic [2:0] tr_addr[64];
  int         resp_cyc;
  int         wr_low;
  int         rd_low;
  int         wr_pulses;
  logic [3:0] bx_seen;
  logic       ok_a;
  logic       ok_b;
  logic       ok_c;

  always #5 clock = ~clock;

  pb_bus_sequencer #(
    .CLOCK_FREQUENCY  (27000000),
    .NUM_BOARDS       (NB),
    .DATA_W           (DW),
    .PRE_DELAY_CYCLES (4),
    .SETUP_CYCLES     (3),
    .STROBE_CYCLES    (2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_mode       (cmd_mode),
    .cmd_board_mask (cmd_board_mask),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_data       (rsp_data),
    .rsp_count      (rsp_count),
    .rsp_error      (rsp_error),
    .BOARD_X        (BOARD_X),
    .AddessPort     (AddessPort),
    .PB_RD          (PB_RD),
    .PB_WR          (PB_WR),
    .Data_Out_Port  (Data_Out_Port),
    .Data_In_Port   (Data_In_Port),
    .data_dir       (data_dir)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, got, exp);
    end
  endtask

  // Issue one command from an idle negedge and trace outputs per cycle until rsp_valid.
  // Cycle k in the trace is the k-th cycle after the accepting clock edge.
  task automatic run_cmd(input logic [1:0] mode, input logic [3:0] mask,
                         input logic [2:0] addr, input logic [31:0] wdata);
    logic prev_wr;
    resp_cyc  = -1;
    wr_low    = 0;
    rd_low    = 0;
    wr_pulses = 0;
    bx_seen   = 4'h0;
    prev_wr   = 1'b1;
    for (int i = 0; i < 64; i++) begin
      tr_bx[i] = 4'h0; tr_wr[i] = 1'b1; tr_rd[i] = 1'b1;
      tr_dir[i] = 1'b0; tr_do[i] = 8'h00; tr_addr[i] = 3'd0;
    end
    cmd_mode       = mode;
    cmd_board_mask = mask;
    cmd_addr       = addr;
    cmd_wdata      = wdata;
    cmd_valid      = 1'b1;
    rsp_ready      = 1'b0;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int k = 1; k < 64; k++) begin
      tr_bx[k]   = BOARD_X;
      tr_wr[k]   = PB_WR;
      tr_rd[k]   = PB_RD;
      tr_dir[k]  = data_dir;
      tr_do[k]   = Data_Out_Port;
      tr_addr[k] = AddessPort;
      bx_seen    = bx_seen | BOARD_X;
      if (!PB_WR) wr_low++;
      if (!PB_RD) rd_low++;
      if (prev_wr && !PB_WR) wr_pulses++;
      prev_wr = PB_WR;
      if (rsp_valid) begin
        resp_cyc = k;
        break;
      end
      // Simple board model: each board returns its own fixed byte while selected
      Data_In_Port = BOARD_X[0] ? 8'h3C : (BOARD_X[1] ? 8'h5A : (BOARD_X[3] ? 8'hC3 : 8'h00));
      @(negedge clock);
    end
  endtask

  task automatic finish_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    check_eq({tag, "_rsp_valid_drop"}, rsp_valid, 1'b0);
    check_eq({tag, "_cmd_ready_back"}, cmd_ready, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset          = 1'b0;
    cmd_valid      = 1'b0;
    cmd_mode       = 2'd0;
    cmd_board_mask = 4'h0;
    cmd_addr       = 3'd0;
    cmd_wdata      = 32'h0;
    rsp_ready      = 1'b0;
    Data_In_Port   = 8'h00;
    repeat (3) @(negedge clock);

    check_eq("rst_cmd_ready", cmd_ready, 1'b1);
    check_eq("rst_rsp_valid", rsp_valid, 1'b0);
    check_eq("rst_rsp_error", rsp_error, 1'b0);
    check_eq("rst_rsp_count", rsp_count, 4'd0);
    check_eq("rst_rsp_data", rsp_data, 32'h0);
    check_eq("rst_board_x", BOARD_X, 4'h0);
    check_eq("rst_addr", AddessPort, 3'd0);
    check_eq("rst_pb_rd", PB_RD, 1'b1);
    check_eq("rst_pb_wr", PB_WR, 1'b1);
    check_eq("rst_data_out", Data_Out_Port, 8'h00);
    check_eq("rst_data_dir", data_dir, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    // Write to boards 0 and 2
    run_cmd(2'd0, 4'b0101, 3'd3, 32'hDDCCBBAA);
    check_eq("wr_resp_cycle", resp_cyc, 21);
    check_eq("wr_b0_select", tr_bx[5], 4'b0001);
    check_eq("wr_b0_data", tr_do[5], 8'hAA);
    check_eq("wr_b0_dir", tr_dir[5], 1'b1);
    check_eq("wr_b0_addr", tr_addr[5], 3'd3);
    check_eq("wr_setup_wr_high", tr_wr[8], 1'b1);
    check_eq("wr_b0_strobe1", tr_wr[9], 1'b0);
    check_eq("wr_b0_strobe2", tr_wr[10], 1'b0);
    check_eq("wr_release_wr", tr_wr[11], 1'b1);
    check_eq("wr_release_bx", tr_bx[11], 4'h0);
    check_eq("wr_release_dir", tr_dir[11], 1'b0);
    check_eq("wr_release_data", tr_do[11], 8'hAA);
    check_eq("wr_next_bx", tr_bx[12], 4'h0);
    check_eq("wr_b2_select", tr_bx[13], 4'b0100);
    check_eq("wr_b2_data", tr_do[13], 8'hCC);
    check_eq("wr_b2_strobe", tr_wr[17], 1'b0);
    check_eq("wr_low_cycles", wr_low, 4);
    check_eq("wr_pulses", wr_pulses, 2);
    check_eq("wr_rd_low", rd_low, 0);
    check_eq("wr_rsp_count", rsp_count, 4'd2);
    check_eq("wr_rsp_error", rsp_error, 1'b0);
    finish_rsp("wr");

    // Read boards 1 and 3, then hold the response for 10 cycles
    run_cmd(2'd1, 4'b1010, 3'd5, 32'h0);
    check_eq("rd_resp_cycle", resp_cyc, 21);
    check_eq("rd_b1_select", tr_bx[5], 4'b0010);
    check_eq("rd_b1_dir", tr_dir[5], 1'b0);
    check_eq("rd_b1_strobe", tr_rd[9], 1'b0);
    check_eq("rd_b1_wr_high", tr_wr[9], 1'b1);
    check_eq("rd_b3_select", tr_bx[13], 4'b1000);
    check_eq("rd_low_cycles", rd_low, 4);
    check_eq("rd_wr_low", wr_low, 0);
    check_eq("rd_rsp_data", rsp_data, 32'hC3005A00);
    check_eq("rd_rsp_count", rsp_count, 4'd2);
    ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b1) ok_a = 1'b0;
      if (rsp_data !== 32'hC3005A00) ok_b = 1'b0;
      if (cmd_ready !== 1'b0) ok_c = 1'b0;
    end
    check_eq("hold_rsp_valid", ok_a, 1'b1);
    check_eq("hold_rsp_data", ok_b, 1'b1);
    check_eq("hold_cmd_ready_low", ok_c, 1'b1);
    finish_rsp("rd");

    // Test mode on board 0: both strobes low, stale read bytes cleared
    run_cmd(2'd2, 4'b0001, 3'd1, 32'h0);
    check_eq("tst_resp_cycle", resp_cyc, 13);
    check_eq("tst_rd_strobe", tr_rd[9], 1'b0);
    check_eq("tst_wr_strobe", tr_wr[9], 1'b0);
    check_eq("tst_rsp_data", rsp_data, 32'h0000003C);
    check_eq("tst_rsp_count", rsp_count, 4'd1);
    finish_rsp("tst");

    // Empty mask
    run_cmd(2'd0, 4'b0000, 3'd2, 32'h12345678);
    check_eq("empty_resp_cycle", resp_cyc, 5);
    check_eq("empty_rsp_count", rsp_count, 4'd0);
    check_eq("empty_wr_low", wr_low, 0);
    check_eq("empty_rd_low", rd_low, 0);
    check_eq("empty_bx", bx_seen, 4'h0);
    finish_rsp("empty");

    // Broadcast
    run_cmd(2'd3, 4'b0011, 3'd7, 32'h11223344);
`ifdef PB_BROADCAST_EN
    check_eq("bc_resp_cycle", resp_cyc, 13);
    check_eq("bc_select_all", tr_bx[5], 4'hF);
    check_eq("bc_data", tr_do[5], 8'h44);
    check_eq("bc_wr_pulses", wr_pulses, 1);
    check_eq("bc_wr_low", wr_low, 2);
    check_eq("bc_rsp_count", rsp_count, 4'd1);
    check_eq("bc_rsp_error", rsp_error, 1'b0);
`else
    check_eq("bc_resp_cycle", resp_cyc, 5);
    check_eq("bc_rsp_error", rsp_error, 1'b1);
    check_eq("bc_rsp_count", rsp_count, 4'd0);
    check_eq("bc_wr_low", wr_low, 0);
    check_eq("bc_bx", bx_seen, 4'h0);
`endif
    finish_rsp("bc");

    // Reset during the second board's strobe aborts without a response
    cmd_mode       = 2'd0;
    cmd_board_mask = 4'b0101;
    cmd_addr       = 3'd3;
    cmd_wdata      = 32'hDDCCBBAA;
    cmd_valid      = 1'b1;
    @(negedge clock);
    cmd_valid = 1'b0;
    repeat (16) @(negedge clock);
    check_eq("abort_in_strobe", PB_WR, 1'b0);
    check_eq("abort_in_strobe_bx", BOARD_X, 4'b0100);
    reset = 1'b0;
    @(negedge clock);
    check_eq("abort_pb_wr", PB_WR, 1'b1);
    check_eq("abort_bx", BOARD_X, 4'h0);
    check_eq("abort_cmd_ready", cmd_ready, 1'b1);
    check_eq("abort_rsp_valid", rsp_valid, 1'b0);
    check_eq("abort_data_dir", data_dir, 1'b0);
    reset = 1'b1;
    ok_a = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0) ok_a = 1'b0;
    end
    check_eq("abort_no_rsp", ok_a, 1'b1);
    check_eq("abort_idle_ready", cmd_ready, 1'b1);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
